// File: rtl/decoder_pkg.sv
// decoder_pkg: shared types and code-field helpers for decoder_mem_arbiter.
//   state_t   - sequencer FSM states
//   mem_sel_t - memory named by the code MSB (0 = key-value, 1 = state-variable)
//   code_sel_bit / code_addr_w - position of the select bit and width of the
//   address field inside a decode code
package decoder_pkg;

  typedef enum logic [1:0] {
    STATE_IDLE     = 2'd0,
    STATE_MEM_WAIT = 2'd1,
    STATE_DATA_OUT = 2'd2
  } state_t;

  typedef enum logic {
    MEM_SEL_KEY_VAL   = 1'b0,
    MEM_SEL_STATE_VAR = 1'b1
  } mem_sel_t;

  // Memory-select bit is the code MSB.
  function automatic int code_sel_bit(input int code_width);
    return code_width - 1;
  endfunction

  // Address field is the low bits of the code, wide enough for one memory.
  function automatic int code_addr_w(input int num_key_val);
    return $clog2(num_key_val);
  endfunction

endpackage

// File: rtl/decoder_mem_arbiter_if.sv
// decoder_mem_arbiter_if: requester-side bus of the decoder memory arbiter.
//   req_valid  - per-requester request
//   req_code   - per-requester decode code (packed, requester i in row i)
//   req_ready  - one-hot grant
//   resp_valid - one-hot single-cycle response pulse
//   resp_data  - response word
//   resp_err   - address-range error, qualified by resp_valid
// Modports: master = decoder front-ends, slave = arbiter.
interface decoder_mem_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int CODE_WIDTH = 7,
  parameter int DATA_WIDTH = 32
);
  logic [NUM_REQ-1:0]                 req_valid;
  logic [NUM_REQ-1:0][CODE_WIDTH-1:0] req_code;
  logic [NUM_REQ-1:0]                 req_ready;
  logic [NUM_REQ-1:0]                 resp_valid;
  logic [DATA_WIDTH-1:0]              resp_data;
  logic                               resp_err;

  modport master (
    output req_valid, req_code,
    input  req_ready, resp_valid, resp_data, resp_err
  );

  modport slave (
    input  req_valid, req_code,
    output req_ready, resp_valid, resp_data, resp_err
  );
endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick.
//   req       - request vector
//   ptr       - index holding highest priority this cycle
//   grant     - one-hot winner (all zero when no request)
//   grant_idx - index of the winner
// The priority pointer register is owned by the caller.
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] grant_idx
);
  localparam int IDX_W = $clog2(NUM_REQ);

  int   idx;
  logic found;

  // Scan from ptr upwards with wrap; first asserted request wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = IDX_W'(idx);
      end
    end
  end
endmodule

// File: rtl/decoder_mem_arbiter.sv
// decoder_mem_arbiter: shares one key-value and one state-variable memory
// (single synchronous read port each, MEM_DELAY read latency) between
// NUM_REQ decoders. One code per transaction: grant, drive both addresses,
// wait MEM_DELAY cycles, return the selected word with a one-hot pulse.
// Ports:
//   clock, reset           - posedge clock, synchronous active-high reset
//   bus (slave)            - request/response bus, see decoder_mem_arbiter_if
//   mem_key_val_addr       - key-value read address
//   mem_state_var_addr     - state-variable read address
//   mem_key_val_data_out   - key-value read data
//   mem_state_var_data_out - state-variable read data
//   busy                   - high when not idle
// Build option: DECODER_ARB_ADDR_CHECK_EN - out-of-range addresses answer
// with data 0 and resp_err=1 (addresses driven 0); otherwise unchecked.
module decoder_mem_arbiter
  import decoder_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int CODE_WIDTH  = 7,
  parameter int NUM_KEY_VAL = 12,
  parameter int NUM_REQ     = 4,
  parameter int MEM_DELAY   = 2
) (
  input  logic                           clock,
  input  logic                           reset,
  decoder_mem_arbiter_if.slave           bus,
  output logic [$clog2(NUM_KEY_VAL)-1:0] mem_key_val_addr,
  output logic [$clog2(NUM_KEY_VAL)-1:0] mem_state_var_addr,
  input  logic [DATA_WIDTH-1:0]          mem_key_val_data_out,
  input  logic [DATA_WIDTH-1:0]          mem_state_var_data_out,
  output logic                           busy
);
  localparam int AW      = code_addr_w(NUM_KEY_VAL);
  localparam int SEL_BIT = code_sel_bit(CODE_WIDTH);
  localparam int IDX_W   = $clog2(NUM_REQ);
  localparam int CNT_W   = $clog2(MEM_DELAY + 1);

  state_t             state, state_nxt;
  logic [NUM_REQ-1:0] grant;
  logic [IDX_W-1:0]   grant_idx, grant_q, ptr;
  logic [CNT_W-1:0]   cnt;
  logic               sel_q;
  logic               handshake;
  logic [AW-1:0]      req_addr;
  logic               req_sel;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req       (bus.req_valid),
    .ptr       (ptr),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign req_addr      = bus.req_code[grant_idx][AW-1:0];
  assign req_sel       = bus.req_code[grant_idx][SEL_BIT];
  assign bus.req_ready = (state == STATE_IDLE && !reset) ? grant : '0;
  assign busy          = (state != STATE_IDLE);

`ifdef DECODER_ARB_ADDR_CHECK_EN
  logic addr_bad, err_q;
  // One extra bit so a power-of-two NUM_KEY_VAL still compares correctly.
  assign addr_bad = ({1'b0, req_addr} >= (AW+1)'(NUM_KEY_VAL));
`else
  assign bus.resp_err = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    handshake = 1'b0;
    case (state)
      STATE_IDLE: begin
        if (|grant && !reset) begin
          handshake = 1'b1;
          state_nxt = STATE_MEM_WAIT;
        end
      end
      // Counter is loaded with MEM_DELAY-1, so this state lasts MEM_DELAY cycles.
      STATE_MEM_WAIT: if (cnt == '0) state_nxt = STATE_DATA_OUT;
      STATE_DATA_OUT: state_nxt = STATE_IDLE;
      default:        state_nxt = STATE_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) state <= STATE_IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ptr                <= '0;
      grant_q            <= '0;
      sel_q              <= 1'b0;
      cnt                <= '0;
      mem_key_val_addr   <= '0;
      mem_state_var_addr <= '0;
      bus.resp_valid     <= '0;
      bus.resp_data      <= '0;
`ifdef DECODER_ARB_ADDR_CHECK_EN
      err_q              <= 1'b0;
      bus.resp_err       <= 1'b0;
`endif
    end else begin
      bus.resp_valid <= '0;
      if (handshake) begin
        grant_q <= grant_idx;
        sel_q   <= req_sel;
        cnt     <= CNT_W'(MEM_DELAY - 1);
        ptr     <= (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + IDX_W'(1);
`ifdef DECODER_ARB_ADDR_CHECK_EN
        err_q              <= addr_bad;
        mem_key_val_addr   <= addr_bad ? '0 : req_addr;
        mem_state_var_addr <= addr_bad ? '0 : req_addr;
`else
        mem_key_val_addr   <= req_addr;
        mem_state_var_addr <= req_addr;
`endif
      end else if (state == STATE_MEM_WAIT && cnt != '0) begin
        cnt <= cnt - CNT_W'(1);
      end
      // Memory data has settled by the closing edge of DATA_OUT.
      if (state == STATE_DATA_OUT) begin
        bus.resp_valid[grant_q] <= 1'b1;
        bus.resp_data <= (mem_sel_t'(sel_q) == MEM_SEL_STATE_VAR) ?
                         mem_state_var_data_out : mem_key_val_data_out;
`ifdef DECODER_ARB_ADDR_CHECK_EN
        bus.resp_err <= err_q;
        if (err_q) bus.resp_data <= '0;
`endif
      end
    end
  end
endmodule
